// File: rtl/wram_bank_ctrl.sv
// Banked work-RAM controller: a fixed bank-0 window plus a switchable window whose bank is
// chosen through an IO-bus register. After reset the whole array is optionally zero-filled
// before CPU requests are accepted. CPU reads return one cycle after acceptance.
module wram_bank_ctrl #(
  parameter int unsigned NUM_BANKS      = 8,
  parameter int unsigned BANK_ADDR_BITS = 12,
  parameter logic [15:0] BASE_ADDR      = 16'hC000,
  parameter logic [15:0] REG_ADDR       = 16'hFF70,
  parameter bit          INIT_ZERO      = 1'b1
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic        I_IN_DMG_MODE,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic [7:0]  I_IOREG_WDATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  output logic [7:0]  O_IOREG_RDATA,
  input  logic [15:0] I_WRAM_ADDR,
  input  logic [7:0]  I_WRAM_WDATA,
  input  logic        I_WRAM_WE_L,
  input  logic        I_WRAM_RE_L,
  output logic        O_WRAM_READY,
  output logic [7:0]  O_WRAM_RDATA,
  output logic        O_WRAM_RVALID
);

  localparam int unsigned SW    = $clog2(NUM_BANKS);
  localparam int unsigned AW    = SW + BANK_ADDR_BITS;
  localparam int unsigned DEPTH = NUM_BANKS * (2 ** BANK_ADDR_BITS);
  localparam logic [AW-1:0] LastLoc = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StFill, StIdle} state_e;

  // Sequencer / handshake state
  state_e          state_q, state_d;
  logic [AW-1:0]   fill_cnt_q, fill_cnt_d;
  logic            ready_q, ready_d;
  logic [SW-1:0]   bank_q, bank_d;
  logic            rvalid_q, rvalid_d;
  logic [7:0]      rdata_q;

  // Storage
  logic [7:0]      mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;

  // Decode
  logic [15:0]     off;
  logic [15:0]     win;
  logic            in_fixed, in_switch;
  logic [SW-1:0]   eff_bank, sel_bank;
  logic [AW-1:0]   phys;
  logic            req, acc, wr_acc, rd_acc;
  logic            reg_hit_w, reg_hit_r;

  // Upper register write-data bits have no storage behind them.
  logic            unused_iowdata;
  assign unused_iowdata = ^I_IOREG_WDATA[7:SW];

  // Window decode; addresses below BASE_ADDR wrap to large offsets and fall outside both windows.
  always_comb begin
    off       = I_WRAM_ADDR - BASE_ADDR;
    win       = off >> BANK_ADDR_BITS;
    in_fixed  = (win == 16'd0);
    in_switch = (win == 16'd1);
    // Bank 0 can never appear in the switchable window; DMG parts only have bank 1 there.
    if (I_IN_DMG_MODE || (bank_q == '0)) begin
      eff_bank = SW'(1);
    end else begin
      eff_bank = bank_q;
    end
    sel_bank = in_fixed ? '0 : eff_bank;
    phys     = {sel_bank, off[BANK_ADDR_BITS-1:0]};
  end

  // Request acceptance; a simultaneous write and read counts as a write only.
  always_comb begin
    req    = !I_WRAM_WE_L || !I_WRAM_RE_L;
    acc    = ready_q && req && (in_fixed || in_switch);
    wr_acc = acc && !I_WRAM_WE_L;
    rd_acc = acc && I_WRAM_WE_L && !I_WRAM_RE_L;
  end

  // Bank register write and combinational readback.
  always_comb begin
    reg_hit_w = !I_IOREG_WE_L && (I_IOREG_ADDR == REG_ADDR) && !I_IN_DMG_MODE;
    reg_hit_r = !I_IOREG_RE_L && (I_IOREG_ADDR == REG_ADDR);
    bank_d    = reg_hit_w ? I_IOREG_WDATA[SW-1:0] : bank_q;
    O_IOREG_RDATA = 8'hFF;
    if (reg_hit_r) begin
      O_IOREG_RDATA = {{(8 - SW){1'b1}}, bank_q};
    end
  end

  // Fill sequencer next state: one zero write per cycle, READY raised after the last one.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    ready_d    = ready_q;
    unique case (state_q)
      StFill: begin
        fill_cnt_d = fill_cnt_q + AW'(1);
        if (fill_cnt_q == LastLoc) begin
          state_d    = StIdle;
          ready_d    = 1'b1;
          fill_cnt_d = '0;
        end
      end
      StIdle: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  // Single memory write port shared by the fill sequencer and CPU writes.
  always_comb begin
    mem_we    = wr_acc;
    mem_waddr = phys;
    mem_wdata = I_WRAM_WDATA;
    if (state_q == StFill) begin
      mem_we    = 1'b1;
      mem_waddr = fill_cnt_q;
      mem_wdata = 8'h00;
    end
  end

  // Read-valid pulse follows each accepted read by one cycle.
  always_comb begin
    rvalid_d = rd_acc;
  end

  // Control state, bank register and registered read path.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q    <= INIT_ZERO ? StFill : StIdle;
      fill_cnt_q <= '0;
      ready_q    <= !INIT_ZERO;
      bank_q     <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      ready_q    <= ready_d;
      bank_q     <= bank_d;
      rvalid_q   <= rvalid_d;
      if (rd_acc) begin
        rdata_q <= mem[phys];
      end
    end
  end

  // Memory array write (no reset; contents are established by the fill sequencer).
  always_ff @(posedge I_CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign O_WRAM_READY  = ready_q;
  assign O_WRAM_RDATA  = rdata_q;
  assign O_WRAM_RVALID = rvalid_q;

endmodule

// File: tb/tb_wram_bank_ctrl.sv
// Directed bench for wram_bank_ctrl with a bank/offset array model checked every cycle.
module tb_wram_bank_ctrl;

  localparam int NB    = 8;
  localparam int BAB   = 4;
  localparam int W     = 16;
  localparam int DEPTH = NB * W;
  localparam logic [15:0] BASE = 16'hC000;
  localparam logic [15:0] REGA = 16'hFF70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmg = 1'b0;
  logic [15:0] io_addr = 16'h0;
  logic [7:0]  io_wdata = 8'h0;
  logic        io_we_l = 1'b1;
  logic        io_re_l = 1'b1;
  logic [7:0]  io_rdata;
  logic [15:0] wr_addr = 16'h0;
  logic [7:0]  wdata = 8'h0;
  logic        we_l = 1'b1;
  logic        re_l = 1'b1;
  logic        ready;
  logic        rvalid;
  logic [7:0]  rdata;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  wram_bank_ctrl #(
    .NUM_BANKS     (NB),
    .BANK_ADDR_BITS(BAB),
    .BASE_ADDR     (BASE),
    .REG_ADDR      (REGA),
    .INIT_ZERO     (1'b1)
  ) dut (
    .I_CLK        (clk),
    .I_RESET_L    (rst_n),
    .I_IN_DMG_MODE(dmg),
    .I_IOREG_ADDR (io_addr),
    .I_IOREG_WDATA(io_wdata),
    .I_IOREG_WE_L (io_we_l),
    .I_IOREG_RE_L (io_re_l),
    .O_IOREG_RDATA(io_rdata),
    .I_WRAM_ADDR  (wr_addr),
    .I_WRAM_WDATA (wdata),
    .I_WRAM_WE_L  (we_l),
    .I_WRAM_RE_L  (re_l),
    .O_WRAM_READY (ready),
    .O_WRAM_RDATA (rdata),
    .O_WRAM_RVALID(rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [NB][W];
  int         m_bank;
  int         m_cnt;   // cycles since reset release, saturating at DEPTH
  logic       exp_rvalid;
  logic [7:0] exp_rdata;
  logic [7:0] exp_io;
  int         m_off, m_b, m_o;
  logic       m_hit, m_acc;

  always_comb begin
    m_off = int'(wr_addr) - int'(BASE);
    m_hit = (m_off >= 0) && (m_off < 2 * W);
    m_o   = m_hit ? (m_off % W) : 0;
    if (m_off < W) m_b = 0;
    else if (dmg || m_bank == 0) m_b = 1;
    else m_b = m_bank;
    m_acc = (m_cnt >= DEPTH) && m_hit && (!we_l || !re_l);
    exp_io = (!io_re_l && io_addr == REGA) ? 8'(256 - NB + m_bank) : 8'hFF;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bank     <= 0;
      m_cnt      <= 0;
      exp_rvalid <= 1'b0;
      exp_rdata  <= 8'h00;
      for (int b = 0; b < NB; b++) begin
        for (int o = 0; o < W; o++) m_mem[b][o] <= 8'h00;
      end
    end else begin
      if (m_acc && !we_l) m_mem[m_b][m_o] <= wdata;
      exp_rvalid <= m_acc && we_l && !re_l;
      if (m_acc && we_l && !re_l) exp_rdata <= m_mem[m_b][m_o];
      if (!io_we_l && io_addr == REGA && !dmg) m_bank <= int'(io_wdata) % NB;
      if (m_cnt < DEPTH) m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", 32'(ready), 32'(m_cnt >= DEPTH));
      chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("io_rdata", 32'(io_rdata), 32'(exp_io));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d,
                      input logic iw, input logic ir, input logic [15:0] ia,
                      input logic [7:0] id);
    @(posedge clk);
    #1;
    we_l = w; re_l = r; wr_addr = a; wdata = d;
    io_we_l = iw; io_re_l = ir; io_addr = ia; io_wdata = id;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, 1'b1, 1'b1, 16'h0, 8'h0);
    idle();
  endtask

  task automatic io_wr(input logic [15:0] ia, input logic [7:0] v);
    step(1'b1, 1'b1, 16'h0, 8'h0, 1'b0, 1'b1, ia, v);
    idle();
  endtask

  task automatic io_rd(input string name, input logic [7:0] exp);
    step(1'b1, 1'b1, 16'h0, 8'h0, 1'b1, 1'b0, REGA, 8'h0);
    @(negedge clk);
    chk(name, 32'(io_rdata), 32'(exp));
    idle();
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    step(1'b1, 1'b0, a, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    idle();
    @(negedge clk);
    chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
    chk(name, 32'(rdata), 32'(exp));
    idle();
    @(negedge clk);
    chk({name, "_rvalid_low"}, 32'(rvalid), 32'd0);
  endtask

  task automatic count_fill(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ready) break;
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: fill length and zeroed contents
    count_fill("fill_len");
    rd_check("t1_zero", 16'hC01F, 8'h00);

    // 2: plain write/read; both strobes low acts as a write
    wr(16'hC003, 8'hA5);
    rd_check("t2_a5", 16'hC003, 8'hA5);
    step(1'b0, 1'b0, 16'hC004, 8'h5A, 1'b1, 1'b1, 16'h0, 8'h0);
    idle();
    @(negedge clk);
    chk("t2_both_low_rvalid", 32'(rvalid), 32'd0);
    rd_check("t2_both_low", 16'hC004, 8'h5A);

    // 3: banking
    io_wr(REGA, 8'h01); wr(16'hC010, 8'h11);
    io_wr(REGA, 8'h03); wr(16'hC010, 8'h33);
    io_wr(REGA, 8'h05); wr(16'hC010, 8'h55);
    io_wr(REGA, 8'h04); wr(16'hC010, 8'h44);
    io_wr(REGA, 8'h03); rd_check("t3_bank3", 16'hC010, 8'h33);
    io_wr(REGA, 8'h05); rd_check("t3_bank5", 16'hC010, 8'h55);
    io_wr(REGA, 8'h00); rd_check("t3_bank0_as1", 16'hC010, 8'h11);
    io_rd("t3_io_f8", 8'hF8);
    io_wr(16'hFF71, 8'h06);
    io_rd("t3_other_addr", 8'hF8);

    // 4: DMG mode blocks register writes and forces bank 1
    io_wr(REGA, 8'h03);
    @(posedge clk);
    #1 dmg = 1'b1;
    io_wr(REGA, 8'h07);
    io_rd("t4_io_fb", 8'hFB);
    rd_check("t4_dmg_bank1", 16'hC010, 8'h11);
    wr(16'hC011, 8'h22);
    @(posedge clk);
    #1 dmg = 1'b0;
    io_wr(REGA, 8'h01);
    rd_check("t4_bank1_22", 16'hC011, 8'h22);

    // 5: same-cycle bank write and read uses the old bank
    io_wr(REGA, 8'h03);
    step(1'b1, 1'b0, 16'hC010, 8'h0, 1'b0, 1'b1, REGA, 8'h04);
    idle();
    @(negedge clk);
    chk("t5_old_rvalid", 32'(rvalid), 32'd1);
    chk("t5_old_bank", 32'(rdata), 32'h33);
    rd_check("t5_new_bank", 16'hC010, 8'h44);
    io_rd("t5_io_fc", 8'hFC);

    // 6a: out-of-window address ignored, no aliasing
    wr(16'hC020, 8'h77);
    step(1'b1, 1'b0, 16'hC020, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    idle();
    @(negedge clk);
    chk("t6_oob_rvalid", 32'(rvalid), 32'd0);
    rd_check("t6_c000", 16'hC000, 8'h00);
    io_wr(REGA, 8'h02);
    rd_check("t6_bank2", 16'hC010, 8'h00);

    // 6b: reset during an in-flight read
    step(1'b1, 1'b0, 16'hC003, 8'h0, 1'b1, 1'b1, 16'h0, 8'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    we_l = 1'b1; re_l = 1'b1;
    @(negedge clk);
    chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rst_rdata", 32'(rdata), 32'd0);
    chk("t6_rst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 6c: reset mid-fill restarts a full fill; requests during fill are dropped
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_midfill_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      count_fill("refill_len");
      begin
        repeat (100) idle();
        step(1'b0, 1'b1, 16'hC000, 8'h99, 1'b1, 1'b1, 16'h0, 8'h0);
        step(1'b1, 1'b0, 16'hC001, 8'h00, 1'b1, 1'b1, 16'h0, 8'h0);
        idle();
      end
    join
    rd_check("t6_fill_drop", 16'hC000, 8'h00);
    rd_check("t6_refilled", 16'hC003, 8'h00);
    io_rd("t6_bank_reset", 8'hF8);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wram_bank_ctrl.md
Name: wram_bank_ctrl

Overview:
- Parametrised banked work-RAM controller; next generation of the fixed 8 x 4 kB GBC WRAM bank block.
- Owns an inferred single-port memory split into NUM_BANKS banks of 2^BANK_ADDR_BITS bytes each.
- Two CPU windows: a fixed bank-0 window and a switchable window selected by a bank register on the IO register bus.
- Adds a post-reset zero-fill sequencer, a ready/valid access handshake and a registered read path; sits behind the memory router and beside the IO register bus.

Parameters:
- NUM_BANKS, 8, number of banks; power of two, 2..64; bank select width SW = clog2(NUM_BANKS).
- BANK_ADDR_BITS, 12, byte address bits per bank; window size = 2^BANK_ADDR_BITS.
- BASE_ADDR, 16'hC000, start of the fixed window; switchable window starts at BASE_ADDR + 2^BANK_ADDR_BITS.
- REG_ADDR, 16'hFF70, IO bus address of the bank select register.
- INIT_ZERO, 1, 1 = zero-fill the whole memory after reset; 0 = skip the fill.

Ports:
- I_CLK  in  1  system clock; all state on rising edge.
- I_RESET_L  in  1  asynchronous active-low reset.
- I_IN_DMG_MODE  in  1  1 = DMG mode: register writes blocked, switchable window forced to bank 1.
- I_IOREG_ADDR  in  16  IO bus address.
- I_IOREG_WDATA  in  8  IO bus write data.
- I_IOREG_WE_L  in  1  IO write strobe, active low.
- I_IOREG_RE_L  in  1  IO read strobe, active low.
- O_IOREG_RDATA  out  8  register readback; 8'hFF when not addressed.
- I_WRAM_ADDR  in  16  CPU address.
- I_WRAM_WDATA  in  8  write data.
- I_WRAM_WE_L  in  1  write request, active low.
- I_WRAM_RE_L  in  1  read request, active low.
- O_WRAM_READY  out  1  accepts requests this cycle.
- O_WRAM_RDATA  out  8  read data; holds its value between reads.
- O_WRAM_RVALID  out  1  one-cycle pulse, O_WRAM_RDATA valid.

Behaviour:
- Reset (async assert, sync release): bank_reg = 0, O_WRAM_RDATA = 8'h00, O_WRAM_RVALID = 0.
  - O_WRAM_READY = 0 if INIT_ZERO, else 1.
  - FSM -> FILL if INIT_ZERO, else IDLE. Fill counter = 0.
- FSM FILL: writes 0 to memory location fill_cnt each cycle, fill_cnt increments.
  - Exits to IDLE after location DEPTH-1, where DEPTH = NUM_BANKS * 2^BANK_ADDR_BITS.
  - O_WRAM_READY rises on the cycle after the last write, i.e. DEPTH cycles after reset release.
  - CPU requests during FILL are dropped: no write, no RVALID.
- FSM IDLE: O_WRAM_READY = 1. A request is accepted at the rising edge where READY = 1 and WE_L or RE_L is low.
- Bank register:
  - Written when I_IOREG_WE_L = 0, I_IOREG_ADDR = REG_ADDR and I_IN_DMG_MODE = 0; bank_reg <= I_IOREG_WDATA[SW-1:0].
  - Readback when RE_L = 0 and the address matches, combinational: {(8-SW) ones, bank_reg}.
  - Register writes are also accepted during FILL.
- Effective bank eff:
  - DMG mode: eff = 1.
  - Otherwise eff = bank_reg, except bank_reg = 0 maps to eff = 1.
- Decode, with off = I_WRAM_ADDR - BASE_ADDR:
  - off < 2^BANK_ADDR_BITS: physical address = off (bank 0).
  - 2^BANK_ADDR_BITS <= off < 2*2^BANK_ADDR_BITS: physical address = {eff, off[BANK_ADDR_BITS-1:0]}.
  - Otherwise the request is ignored: no write, no RVALID.
- Write: memory updates at the accepting edge.
- Read: data from the accepting edge appears on O_WRAM_RDATA with O_WRAM_RVALID = 1 in the next cycle (latency 1). RVALID is held high for one cycle per read, so back-to-back reads give one pulse each.
- WE_L and RE_L both low: treated as a write; no RVALID.
- Bank register write in the same cycle as a WRAM access: the access uses the old bank; the new bank applies from the next edge.
- An in-flight read returns the bank selected at request time.
- Async reset mid-FILL or mid-read: everything returns to reset values immediately, RVALID is suppressed, and FILL restarts from 0.

Test Plan:
1. INIT_ZERO = 1, NUM_BANKS = 8, BANK_ADDR_BITS = 4 (DEPTH = 128); release reset -> READY = 0 for exactly 128 cycles, then 1; a read of any address returns 8'h00 with RVALID one cycle after the request.
2. Write 8'hA5 to 16'hC003, then read it back -> RDATA = 8'hA5 with RVALID exactly one cycle after the request, RVALID low the following cycle.
3. Bank 3: write bank_reg = 3, write 8'h33 to the first switchable-window location; bank 5: write 8'h55 to the same address -> reading the address in bank 3 returns 8'h33 and in bank 5 returns 8'h55. Then write bank_reg = 0 -> reading the address returns bank 1's content; IO read of REG_ADDR returns 8'hF8.
4. I_IN_DMG_MODE = 1, IO write 8'h07 to REG_ADDR -> register unchanged; switchable window accesses hit bank 1.
5. Same cycle: IO write bank_reg = 4 and a WRAM read of the switchable window -> the read returns old-bank data; the next read returns bank 4 data.
6. Edge cases: request during FILL -> no RVALID, memory stays zero. Address BASE_ADDR + 2*2^BANK_ADDR_BITS -> ignored. Reset pulsed mid-FILL -> READY = 0 and a full DEPTH-cycle fill repeats.
